// File: rtl/rf_bypass_sb_pkg.sv
// rf_bypass_sb_pkg: shared register-file constants and index types
package rf_bypass_sb_pkg;
    localparam int RF_WIDTH = 16;
    localparam int RF_NREG  = 8;
    localparam int RF_SEL_W = 3;
    typedef logic [RF_SEL_W-1:0] sel_t;
endpackage

// File: rtl/rf_en_reg.sv
// rf_en_reg: enabled data register with asynchronous clear
module rf_en_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] data_q;
    // load on enable, otherwise hold
    always_ff @(posedge clk or posedge rst)
        if (rst) data_q <= '0;
        else if (en_i) data_q <= d_i;
    assign q_o = data_q;
endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write tracking with writeback-aware ready
module rf_scoreboard #(
    parameter int NREG = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREG-1:0] set,
    input  logic [NREG-1:0] clear,
    output logic [NREG-1:0] busy,
    output logic [NREG-1:0] ready
);
    logic [NREG-1:0] busy_q, busy_d;
    // a new producer outranks a writeback landing on the same register
    always_comb busy_d = (busy_q & ~clear) | set;
    // pending-write bits
    always_ff @(posedge clk or posedge rst)
        if (rst) busy_q <= '0;
        else busy_q <= busy_d;
    assign busy  = busy_q;
    assign ready = ~busy_q | clear;
endmodule

// File: rtl/rf_bypass_sb.sv
// rf_bypass_sb: register file with same-cycle write bypass and scoreboard hazard detection
module rf_bypass_sb
    import rf_bypass_sb_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int NREG  = RF_NREG
) (
    input  logic             clk,
    input  logic             rst,
    input  sel_t             read1RegSel,
    input  logic             read1En,
    input  sel_t             read2RegSel,
    input  logic             read2En,
    output logic [WIDTH-1:0] read1Data,
    output logic [WIDTH-1:0] read2Data,
    input  sel_t             writeRegSel,
    input  logic [WIDTH-1:0] writeData,
    input  logic             writeEn,
    input  logic             issueEn,
    input  sel_t             issueRegSel,
    output logic             stall,
    output logic             err
);
    logic [WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]  wr_dec, set_vec, busy, ready;
    logic             err_q, err_d;

    assign wr_dec = writeEn ? NREG'(1) << writeRegSel : '0;

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        rf_en_reg #(.W(WIDTH)) u_reg (
            .clk  (clk),
            .rst  (rst),
            .en_i (wr_dec[g]),
            .d_i  (writeData),
            .q_o  (regs[g])
        );
    end

    rf_scoreboard #(.NREG(NREG)) u_sb (
        .clk   (clk),
        .rst   (rst),
        .set   (set_vec),
        .clear (wr_dec),
        .busy  (busy),
        .ready (ready)
    );

    assign read1Data = (writeEn && writeRegSel == read1RegSel) ? writeData : regs[read1RegSel];
    assign read2Data = (writeEn && writeRegSel == read2RegSel) ? writeData : regs[read2RegSel];

    // RAW on either source or WAW on the destination holds decode
    always_comb begin
        stall   = (read1En && !ready[read1RegSel]) || (read2En && !ready[read2RegSel]) ||
                  (issueEn && !ready[issueRegSel]);
        set_vec = (issueEn && !stall) ? NREG'(1) << issueRegSel : '0;
        err_d   = writeEn && !busy[writeRegSel];
    end

    // flag a writeback nobody was waiting for, one cycle late
    always_ff @(posedge clk or posedge rst)
        if (rst) err_q <= 1'b0;
        else err_q <= err_d;
    assign err = err_q;
endmodule
